// File: rtl/axi_sram_pkg.sv
// ---------------------------------------------------------------------------
// axi_sram_pkg
// Shared types and helpers for the AXI-style SRAM slave.
//   - sram_state_t : controller states (one burst in flight at a time)
//   - ID_WIDTH     : AXI transaction ID width
//   - LEN_WIDTH    : AXI burst length field width (beats - 1)
//   - addr_to_word : byte address -> word address (drops byte offset)
// ---------------------------------------------------------------------------
package axi_sram_pkg;

    localparam int ID_WIDTH       = 4;
    localparam int LEN_WIDTH      = 4;
    // Beat counter holds LEN+1, so it needs one extra bit.
    localparam int BEAT_CNT_WIDTH = LEN_WIDTH + 1;
    // Widest byte address the helper accepts; callers cast in and out.
    localparam int MAX_ADDR_WIDTH = 64;
    localparam int WAIT_WIDTH     = 8;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WR_DATA  = 3'd1,
        ST_WR_RESP  = 3'd2,
        ST_RD_WAIT  = 3'd3,
        ST_RD_BURST = 3'd4
    } sram_state_t;

    // Byte address to word address. The caller truncates the result to the
    // SRAM index width, which both drops the upper address bits and makes
    // the index wrap modulo the SRAM depth.
    function automatic logic [MAX_ADDR_WIDTH-1:0] addr_to_word(
        input logic [MAX_ADDR_WIDTH-1:0] byte_addr
    );
        return {2'b00, byte_addr[MAX_ADDR_WIDTH-1:2]};
    endfunction

endpackage

// File: rtl/axi_sram_slave_sram.sv
// ---------------------------------------------------------------------------
// sp_sram
// Single-port synchronous SRAM: one read or one write per cycle, read data
// appears one cycle after the read is issued and holds until the next read.
// Contents are never cleared.
// Ports:
//   clk   in   clock
//   en    in   access enable
//   we    in   write enable (write when en && we, read when en && !we)
//   addr  in   word index
//   wdata in   write data
//   rdata out  registered read data
// ---------------------------------------------------------------------------
module sp_sram #(
    parameter int    DATA_WIDTH = 32,
    parameter int    DEPTH_LOG2 = 14,
    parameter string INIT_FILE  = ""
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem_q [0:(2**DEPTH_LOG2)-1];
    logic [DATA_WIDTH-1:0] rdata_q;

    // Single port: a write suppresses the read, so rdata holds its last value.
    always_ff @(posedge clk) begin
        if (en && we) begin
            mem_q[addr] <= wdata;
        end else if (en) begin
            rdata_q <= mem_q[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/axi_sram_slave.sv
// ---------------------------------------------------------------------------
// axi_sram_slave
// AXI-style slave that terminates bursts in an on-chip single-port SRAM.
// One burst is served at a time; writes win over reads when both arrive
// together. Reads wait RD_LATENCY extra cycles before the first SRAM access
// to emulate DRAM, then stream one beat per cycle while RREADY is high.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   AWVALID/AWREADY, AWID/AWLEN/AWADDR   write address channel
//   WVALID/WREADY, WLAST/WID/WDATA       write data (WLAST/WID unused)
//   BVALID/BREADY, BID                   write response
//   ARVALID/ARREADY, ARID/ARLEN/ARADDR   read address channel
//   RVALID/RREADY, RLAST/RID/RDATA       read data (RDATA zero when idle)
// ---------------------------------------------------------------------------
module axi_sram_slave
    import axi_sram_pkg::*;
#(
    parameter int    ADDR_WIDTH = 26,
    parameter int    DATA_WIDTH = 32,
    parameter int    DEPTH_LOG2 = 14,
    parameter int    RD_LATENCY = 4,
    parameter string INIT_FILE  = ""
) (
    input  logic                  clk,
    input  logic                  rst,
    // write address
    input  logic                  AWVALID,
    output logic                  AWREADY,
    input  logic [ID_WIDTH-1:0]   AWID,
    input  logic [LEN_WIDTH-1:0]  AWLEN,
    input  logic [ADDR_WIDTH-1:0] AWADDR,
    // write data
    input  logic                  WVALID,
    output logic                  WREADY,
    input  logic                  WLAST,
    input  logic [ID_WIDTH-1:0]   WID,
    input  logic [DATA_WIDTH-1:0] WDATA,
    // write response
    output logic                  BVALID,
    input  logic                  BREADY,
    output logic [ID_WIDTH-1:0]   BID,
    // read address
    input  logic                  ARVALID,
    output logic                  ARREADY,
    input  logic [ID_WIDTH-1:0]   ARID,
    input  logic [LEN_WIDTH-1:0]  ARLEN,
    input  logic [ADDR_WIDTH-1:0] ARADDR,
    // read data
    output logic                  RVALID,
    input  logic                  RREADY,
    output logic                  RLAST,
    output logic [ID_WIDTH-1:0]   RID,
    output logic [DATA_WIDTH-1:0] RDATA
);

    sram_state_t               state_q, state_d;
    logic [ID_WIDTH-1:0]       id_q, id_d;
    logic [BEAT_CNT_WIDTH-1:0] beats_q, beats_d;   // beats still to transfer
    logic [DEPTH_LOG2-1:0]     idx_q, idx_d;       // current SRAM word index
    logic [WAIT_WIDTH-1:0]     wait_q, wait_d;     // read first-beat delay

    logic                  aw_hs_s;
    logic                  ar_hs_s;
    logic [DEPTH_LOG2-1:0] aw_idx_s;
    logic [DEPTH_LOG2-1:0] ar_idx_s;
    logic                  sram_en_s;
    logic                  sram_we_s;
    logic [DEPTH_LOG2-1:0] sram_addr_s;
    logic [DATA_WIDTH-1:0] sram_rdata_s;

    // Burst-end markers and write IDs play no part in burst tracking.
    logic unused_inputs_s;
    assign unused_inputs_s = ^{WLAST, WID};

    // Truncating the word address to the index width gives the wrap.
    assign aw_idx_s = DEPTH_LOG2'(addr_to_word(MAX_ADDR_WIDTH'(AWADDR)));
    assign ar_idx_s = DEPTH_LOG2'(addr_to_word(MAX_ADDR_WIDTH'(ARADDR)));

    assign aw_hs_s = AWVALID && AWREADY;
    assign ar_hs_s = ARVALID && ARREADY;

    // State and burst-context registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            id_q    <= {ID_WIDTH{1'b0}};
            beats_q <= {BEAT_CNT_WIDTH{1'b0}};
            idx_q   <= {DEPTH_LOG2{1'b0}};
            wait_q  <= {WAIT_WIDTH{1'b0}};
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            beats_q <= beats_d;
            idx_q   <= idx_d;
            wait_q  <= wait_d;
        end
    end

    // Next-state, burst context and SRAM access control.
    always_comb begin
        state_d     = state_q;
        id_d        = id_q;
        beats_d     = beats_q;
        idx_d       = idx_q;
        wait_d      = wait_q;
        sram_en_s   = 1'b0;
        sram_we_s   = 1'b0;
        sram_addr_s = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (aw_hs_s) begin
                    id_d    = AWID;
                    beats_d = {1'b0, AWLEN} + {{(BEAT_CNT_WIDTH-1){1'b0}}, 1'b1};
                    idx_d   = aw_idx_s;
                    state_d = ST_WR_DATA;
                end else if (ar_hs_s) begin
                    id_d    = ARID;
                    beats_d = {1'b0, ARLEN} + {{(BEAT_CNT_WIDTH-1){1'b0}}, 1'b1};
                    idx_d   = ar_idx_s;
                    wait_d  = WAIT_WIDTH'(RD_LATENCY);
                    state_d = ST_RD_WAIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WR_DATA: begin
                if (WVALID) begin
                    sram_en_s = 1'b1;
                    sram_we_s = 1'b1;
                    idx_d     = idx_q + {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
                    beats_d   = beats_q - {{(BEAT_CNT_WIDTH-1){1'b0}}, 1'b1};
                    // The beat count alone terminates the burst.
                    if (beats_q == {{(BEAT_CNT_WIDTH-1){1'b0}}, 1'b1}) begin
                        state_d = ST_WR_RESP;
                    end else begin
                        state_d = ST_WR_DATA;
                    end
                end else begin
                    state_d = ST_WR_DATA;
                end
            end
            ST_WR_RESP: begin
                if (BREADY) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WR_RESP;
                end
            end
            ST_RD_WAIT: begin
                if (wait_q == {WAIT_WIDTH{1'b0}}) begin
                    // Beat 0 read; data is on the SRAM output next cycle.
                    sram_en_s = 1'b1;
                    state_d   = ST_RD_BURST;
                end else begin
                    wait_d  = wait_q - {{(WAIT_WIDTH-1){1'b0}}, 1'b1};
                    state_d = ST_RD_WAIT;
                end
            end
            ST_RD_BURST: begin
                // Re-read every cycle: the current index while stalled keeps
                // RDATA stable, the next index on a handshake prefetches.
                sram_en_s = 1'b1;
                if (RREADY) begin
                    sram_addr_s = idx_q + {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
                    idx_d       = idx_q + {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
                    beats_d     = beats_q - {{(BEAT_CNT_WIDTH-1){1'b0}}, 1'b1};
                    if (beats_q == {{(BEAT_CNT_WIDTH-1){1'b0}}, 1'b1}) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_RD_BURST;
                    end
                end else begin
                    sram_addr_s = idx_q;
                    state_d     = ST_RD_BURST;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Reset aborts the burst; it must not also commit a write beat.
        if (rst) begin
            sram_en_s = 1'b0;
        end else begin
            sram_en_s = sram_en_s;
        end
    end

    // Channel outputs decoded from the registered state.
    always_comb begin
        AWREADY = (state_q == ST_IDLE) && !rst;
        ARREADY = (state_q == ST_IDLE) && !AWVALID && !rst;
        WREADY  = (state_q == ST_WR_DATA);
        BVALID  = (state_q == ST_WR_RESP);
        BID     = id_q;
        RVALID  = (state_q == ST_RD_BURST);
        RLAST   = (state_q == ST_RD_BURST) &&
                  (beats_q == {{(BEAT_CNT_WIDTH-1){1'b0}}, 1'b1});
        RID     = id_q;
        if (state_q == ST_RD_BURST) begin
            RDATA = sram_rdata_s;
        end else begin
            RDATA = {DATA_WIDTH{1'b0}};
        end
    end

    sp_sram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH_LOG2 (DEPTH_LOG2),
        .INIT_FILE  (INIT_FILE)
    ) u_sram (
        .clk   (clk),
        .en    (sram_en_s),
        .we    (sram_we_s),
        .addr  (sram_addr_s),
        .wdata (WDATA),
        .rdata (sram_rdata_s)
    );

endmodule

// File: tb/tb_axi_sram_slave.sv
// ---------------------------------------------------------------------------
// tb_axi_sram_slave
// Self-checking bench: directed scenarios plus randomized bursts, checked
// against a word-array memory model and the protocol timing rules.
// ---------------------------------------------------------------------------
module tb_axi_sram_slave;

    localparam int AW    = 26;
    localparam int DW    = 32;
    localparam int DL    = 14;
    localparam int RL    = 4;
    localparam int DEPTH = 1 << DL;

    logic          clk = 1'b0;
    logic          rst;
    logic          AWVALID, AWREADY;
    logic [3:0]    AWID, AWLEN;
    logic [AW-1:0] AWADDR;
    logic          WVALID, WREADY, WLAST;
    logic [3:0]    WID;
    logic [DW-1:0] WDATA;
    logic          BVALID, BREADY;
    logic [3:0]    BID;
    logic          ARVALID, ARREADY;
    logic [3:0]    ARID, ARLEN;
    logic [AW-1:0] ARADDR;
    logic          RVALID, RREADY, RLAST;
    logic [3:0]    RID;
    logic [DW-1:0] RDATA;

    int checks = 0;
    int errors = 0;

    // Reference memory: word array indexed by (byte address / 4) mod depth.
    logic [DW-1:0] mdata  [DEPTH];
    bit            mknown [DEPTH];

    axi_sram_slave #(
        .ADDR_WIDTH (AW), .DATA_WIDTH (DW), .DEPTH_LOG2 (DL),
        .RD_LATENCY (RL), .INIT_FILE ("")
    ) dut (
        .clk (clk), .rst (rst),
        .AWVALID (AWVALID), .AWREADY (AWREADY), .AWID (AWID), .AWLEN (AWLEN), .AWADDR (AWADDR),
        .WVALID (WVALID), .WREADY (WREADY), .WLAST (WLAST), .WID (WID), .WDATA (WDATA),
        .BVALID (BVALID), .BREADY (BREADY), .BID (BID),
        .ARVALID (ARVALID), .ARREADY (ARREADY), .ARID (ARID), .ARLEN (ARLEN), .ARADDR (ARADDR),
        .RVALID (RVALID), .RREADY (RREADY), .RLAST (RLAST), .RID (RID), .RDATA (RDATA)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int widx(input logic [AW-1:0] a);
        return int'(a >> 2) % DEPTH;
    endfunction

    function automatic logic [45:0] all_outs();
        return {AWREADY, ARREADY, WREADY, BVALID, RVALID, RLAST, BID, RID, RDATA};
    endfunction

    // Write burst with timing checks; updates the reference memory.
    task automatic do_write(input logic [3:0] id, input int len, input logic [AW-1:0] addr,
                            input logic [31:0] base, input bit rnd, input int wlast_at,
                            input bit ar_pending);
        int n = 0;
        int idx = widx(addr);
        int gaps;
        logic [31:0] d;
        AWVALID = 1'b1; AWID = id; AWLEN = 4'(len); AWADDR = addr;
        #1;
        while (!AWREADY && n < 20) begin tick(); n++; end
        checks++;
        if (AWREADY !== 1'b1) begin
            errors++; $display("FAIL aw_accept: AWREADY=%b required 1", AWREADY);
            AWVALID = 1'b0; return;
        end
        if (ar_pending) begin
            checks++;
            if (ARREADY !== 1'b0) begin
                errors++; $display("FAIL ar_blocked_by_aw: ARREADY=%b required 0", ARREADY);
            end
        end
        tick();
        AWVALID = 1'b0; AWID = 4'($urandom); AWADDR = AW'($urandom);
        checks++;
        if (WREADY !== 1'b1) begin
            errors++; $display("FAIL wready_after_aw: WREADY=%b required 1", WREADY);
        end
        for (int b = 0; b <= len; b++) begin
            if (rnd && $urandom_range(0, 3) == 0) begin
                WVALID = 1'b0; tick();
            end
            d = rnd ? 32'($urandom) : base + 32'(b);
            WVALID = 1'b1; WDATA = d; WLAST = (b == wlast_at); WID = 4'($urandom);
            checks++;
            if ({WREADY, BVALID, ARREADY} !== 3'b100) begin
                errors++;
                $display("FAIL w_beat%0d: WREADY/BVALID/ARREADY=%b required 100", b,
                         {WREADY, BVALID, ARREADY});
            end
            mdata[(idx + b) % DEPTH]  = d;
            mknown[(idx + b) % DEPTH] = 1'b1;
            tick();
        end
        WVALID = 1'b0; WLAST = 1'b0;
        checks++;
        if ({BVALID, WREADY, BID} !== {1'b1, 1'b0, id}) begin
            errors++;
            $display("FAIL b_resp: BVALID/WREADY/BID=%b/%b/%h required 1/0/%h", BVALID, WREADY, BID, id);
        end
        gaps = $urandom_range(0, 2);
        for (int g = 0; g < gaps; g++) begin
            tick();
            checks++;
            if ({BVALID, BID} !== {1'b1, id}) begin
                errors++; $display("FAIL b_hold: BVALID/BID=%b/%h required 1/%h", BVALID, BID, id);
            end
        end
        BREADY = 1'b1; tick(); BREADY = 1'b0;
        checks++;
        if ({BVALID, AWREADY} !== 2'b01) begin
            errors++; $display("FAIL idle_after_b: BVALID/AWREADY=%b required 01", {BVALID, AWREADY});
        end
    endtask

    // Read burst: mode 0 ready always, 1 toggle, 2 random. abort_at >= 0
    // asserts reset after that many beats have been accepted.
    task automatic do_read(input logic [3:0] id, input int len, input logic [AW-1:0] addr,
                           input int mode, input int abort_at, input bit expect_immediate);
        int n = 0;
        int b = 0;
        int guard = 0;
        int idx = widx(addr);
        bit rr;
        ARVALID = 1'b1; ARID = id; ARLEN = 4'(len); ARADDR = addr;
        #1;
        while (!ARREADY && n < 20) begin tick(); n++; end
        checks++;
        if (ARREADY !== 1'b1 || (expect_immediate && n != 0)) begin
            errors++; $display("FAIL ar_accept: ARREADY=%b waited %0d cycles", ARREADY, n);
            if (ARREADY !== 1'b1) begin ARVALID = 1'b0; return; end
        end
        tick();
        ARVALID = 1'b0; ARADDR = AW'($urandom);
        for (int k = 0; k <= RL; k++) begin
            checks++;
            if ({RVALID, RDATA} !== 33'd0) begin
                errors++; $display("FAIL rd_latency_idle: cycle %0d RVALID=%b RDATA=%h required 0/0", k, RVALID, RDATA);
            end
            tick();
        end
        checks++;
        if (RVALID !== 1'b1) begin
            errors++; $display("FAIL rd_first_valid: RVALID=%b required 1", RVALID); return;
        end
        while (b <= len && guard < 100) begin
            guard++;
            case (mode)
                1:       rr = (guard % 2) == 1;
                2:       rr = 1'($urandom_range(0, 1));
                default: rr = 1'b1;
            endcase
            if (abort_at >= 0 && b == abort_at) begin
                rst = 1'b1; RREADY = 1'b1; tick();
                checks++;
                if (all_outs() !== 46'd0) begin
                    errors++; $display("FAIL reset_outputs: outputs=%h required 0", all_outs());
                end
                rst = 1'b0; RREADY = 1'b0; #1;
                checks++;
                if ({AWREADY, ARREADY} !== 2'b11) begin
                    errors++; $display("FAIL ready_after_reset: AWREADY/ARREADY=%b required 11", {AWREADY, ARREADY});
                end
                return;
            end
            RREADY = rr;
            checks++;
            if ({RVALID, RID, RLAST} !== {1'b1, id, (b == len)}) begin
                errors++;
                $display("FAIL r_ctrl beat%0d: RVALID/RID/RLAST=%b/%h/%b required 1/%h/%b",
                         b, RVALID, RID, RLAST, id, (b == len));
            end
            if (mknown[(idx + b) % DEPTH]) begin
                checks++;
                if (RDATA !== mdata[(idx + b) % DEPTH]) begin
                    errors++;
                    $display("FAIL r_data beat%0d: RDATA=%h required %h", b, RDATA, mdata[(idx + b) % DEPTH]);
                end
            end
            tick();
            if (rr) b++;
        end
        RREADY = 1'b0;
        checks++;
        if (b != len + 1 || {RVALID, RLAST, RDATA} !== 34'd0) begin
            errors++;
            $display("FAIL rd_end: beats=%0d RVALID/RLAST=%b RDATA=%h required %0d/00/0",
                     b, {RVALID, RLAST}, RDATA, len + 1);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        checks++;
        if (all_outs() !== 46'd0) begin
            errors++; $display("FAIL reset_state: outputs=%h required 0", all_outs());
        end
        rst = 1'b0; #1;
        checks++;
        if ({AWREADY, ARREADY, WREADY, BVALID, RVALID} !== 5'b11000) begin
            errors++;
            $display("FAIL ready_after_rst: AW/AR/W/B/R=%b required 11000",
                     {AWREADY, ARREADY, WREADY, BVALID, RVALID});
        end
    endtask

    task automatic test_write_read();
        do_write(4'd5, 3, 26'h100, 32'hA0, 1'b0, -1, 1'b0);
        do_read(4'd5, 3, 26'h100, 0, -1, 1'b0);
    endtask

    task automatic test_backpressure();
        do_write(4'd7, 7, 26'h400, 32'hB00, 1'b0, -1, 1'b0);
        do_read(4'd7, 7, 26'h400, 1, -1, 1'b0);
    endtask

    task automatic test_simultaneous();
        ARVALID = 1'b1; ARID = 4'd12; ARLEN = 4'd2; ARADDR = 26'h104;
        do_write(4'd11, 2, 26'h200, 32'hD0, 1'b1, -1, 1'b1);
        do_read(4'd12, 2, 26'h104, 0, -1, 1'b1);
        do_read(4'd11, 2, 26'h200, 2, -1, 1'b0);
    endtask

    task automatic test_wrap();
        logic [AW-1:0] a_last;
        logic [AW-1:0] a_zero;
        a_last = {10'($urandom), 14'h3FFF, 2'b11};
        a_zero = {10'($urandom), 14'h0000, 2'b10};
        do_write(4'd2, 1, a_last, 32'hE0, 1'b0, -1, 1'b0);
        do_read(4'd2, 0, a_zero, 0, -1, 1'b0);
        do_read(4'd3, 1, a_last, 2, -1, 1'b0);
    endtask

    task automatic test_wlast_mismatch();
        do_write(4'd3, 3, 26'h2000, 32'h5000, 1'b0, 1, 1'b0);
        do_read(4'd3, 3, 26'h2000, 0, -1, 1'b0);
    endtask

    task automatic test_reset_mid_read();
        do_write(4'd9, 7, 26'h800, 32'hC0, 1'b0, -1, 1'b0);
        do_read(4'd9, 7, 26'h800, 0, 3, 1'b0);
        do_read(4'd9, 0, 26'h800, 0, -1, 1'b0);
    endtask

    task automatic test_random();
        logic [AW-1:0] last_addr;
        logic [AW-1:0] a;
        last_addr = 26'h0;
        for (int i = 0; i < 24; i++) begin
            a = ($urandom_range(0, 1) == 1) ? last_addr : AW'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                do_write(4'($urandom), $urandom_range(0, 15), a, 32'h0, 1'b1, $urandom_range(0, 15), 1'b0);
                last_addr = a;
            end else begin
                do_read(4'($urandom), $urandom_range(0, 15), a, $urandom_range(0, 2), -1, 1'b0);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        AWVALID = 1'b0; AWID = 4'd0; AWLEN = 4'd0; AWADDR = 26'd0;
        WVALID = 1'b0; WLAST = 1'b0; WID = 4'd0; WDATA = 32'd0; BREADY = 1'b0;
        ARVALID = 1'b0; ARID = 4'd0; ARLEN = 4'd0; ARADDR = 26'd0; RREADY = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            mknown[i] = 1'b0;
            mdata[i]  = 32'd0;
        end
        test_reset();
        test_write_read();
        test_backpressure();
        test_simultaneous();
        test_wrap();
        test_wlast_mismatch();
        test_reset_mid_read();
        test_random();
        repeat (2) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
